// File: rtl/vx_dp_ram_asic.sv
// Simple-dual-port (1R/1W) behavioural RAM for ASIC flows: byte-lane writes,
// 1..3 cycle read latency, selectable read-during-write and post-reset zeroing.
module vx_dp_ram_asic #(
    parameter int DATAW      = 32,
    parameter int SIZE       = 64,
    parameter int WRENW      = 4,
    parameter int ADDRW      = (SIZE > 1) ? $clog2(SIZE) : 1,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0,
    parameter int INIT_ZERO  = 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic             ready,
    input  logic             read,
    input  logic [ADDRW-1:0] raddr,
    input  logic             write,
    input  logic [WRENW-1:0] wren,
    input  logic [ADDRW-1:0] waddr,
    input  logic [DATAW-1:0] wdata,
    output logic             rvalid,
    output logic [DATAW-1:0] rdata,
    output logic [0:0]       o_dbg_state
);

    localparam int               WSELW     = DATAW / WRENW;
    localparam logic [31:0]      SIZE_U    = 32'(SIZE);
    localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(SIZE - 1);

    generate
        if (DATAW % WRENW != 0) begin : g_bad_lanes
            $error("vx_dp_ram_asic: DATAW must be a multiple of WRENW");
        end
        if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_bad_latency
            $error("vx_dp_ram_asic: RD_LATENCY must be 1..3");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (INIT_ZERO != 0) ? S_INIT : S_RUN;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ADDRW-1:0] r_cnt;
    logic [ADDRW-1:0] w_cnt_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RESET_STATE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_INIT: begin
                w_cnt_nxt = r_cnt + ADDRW'(1);
                if (r_cnt == LAST_ADDR) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end
            end
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = RESET_STATE;
        endcase
    end

    assign o_dbg_state = r_state;

    // Handshake: read/write are taken on a rising edge only while ready is high;
    // every taken read yields exactly one rvalid pulse RD_LATENCY cycles later.
    assign ready = (r_state == S_RUN) && !reset;

    logic w_rd_fire;
    logic w_wr_fire;
    logic w_raddr_ok;
    logic w_waddr_ok;

    assign w_raddr_ok = (32'(raddr) < SIZE_U);
    assign w_waddr_ok = (32'(waddr) < SIZE_U);
    assign w_rd_fire  = read && ready;
    assign w_wr_fire  = write && ready && w_waddr_ok;

    logic [DATAW-1:0] r_mem [SIZE];

    always_ff @(posedge clk) begin
        if (r_state == S_INIT) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_fire) begin
            for (int i = 0; i < WRENW; i++) begin
                if (wren[i]) begin
                    r_mem[waddr][i*WSELW +: WSELW] <= wdata[i*WSELW +: WSELW];
                end
            end
        end
    end

    // The array read sees pre-edge contents, so old-data behaviour needs no logic.
    logic [DATAW-1:0] w_rd_word;

    always_comb begin
        w_rd_word = '0;
        if (w_raddr_ok) begin
            w_rd_word = r_mem[raddr];
            if (RDW_MODE == 1 && w_wr_fire && waddr == raddr) begin
                for (int i = 0; i < WRENW; i++) begin
                    if (wren[i]) begin
                        w_rd_word[i*WSELW +: WSELW] = wdata[i*WSELW +: WSELW];
                    end
                end
            end
        end
    end

    logic [RD_LATENCY-1:0] r_pipe_vld;
    logic [DATAW-1:0]      r_pipe_dat [RD_LATENCY];

    // Data stages only load behind a valid, so the last stage holds between pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pipe_vld <= '0;
            for (int k = 0; k < RD_LATENCY; k++) begin
                r_pipe_dat[k] <= '0;
            end
        end else begin
            r_pipe_vld[0] <= w_rd_fire;
            if (w_rd_fire) begin
                r_pipe_dat[0] <= w_rd_word;
            end
            for (int k = 1; k < RD_LATENCY; k++) begin
                r_pipe_vld[k] <= r_pipe_vld[k-1];
                if (r_pipe_vld[k-1]) begin
                    r_pipe_dat[k] <= r_pipe_dat[k-1];
                end
            end
        end
    end

    assign rvalid = r_pipe_vld[RD_LATENCY-1];
    assign rdata  = r_pipe_dat[RD_LATENCY-1];

endmodule

// File: tb/tb_vx_dp_ram_asic.sv
// Bench for vx_dp_ram_asic: two instances (SIZE=48/lat 3/write-through and
// the default SIZE=64/lat 1/old-data) share stimulus, each against its own model.
module tb_vx_dp_ram_asic;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        read;
    logic [5:0]  raddr;
    logic        write;
    logic [3:0]  wren;
    logic [5:0]  waddr;
    logic [31:0] wdata;

    logic        ready_a, rvalid_a, ready_b, rvalid_b;
    logic [31:0] rdata_a, rdata_b;
    logic [0:0]  dbg_a, dbg_b;

    int checks = 0;
    int errors = 0;

    vx_dp_ram_asic #(.SIZE(48), .RD_LATENCY(3), .RDW_MODE(1)) u_dut_a (
        .clk(clk), .reset(reset), .ready(ready_a), .read(read), .raddr(raddr),
        .write(write), .wren(wren), .waddr(waddr), .wdata(wdata),
        .rvalid(rvalid_a), .rdata(rdata_a), .o_dbg_state(dbg_a)
    );

    vx_dp_ram_asic u_dut_b (
        .clk(clk), .reset(reset), .ready(ready_b), .read(read), .raddr(raddr),
        .write(write), .wren(wren), .waddr(waddr), .wdata(wdata),
        .rvalid(rvalid_b), .rdata(rdata_b), .o_dbg_state(dbg_b)
    );

    // Reference model: per-instance word array, init progress, and a queue of
    // read results tagged with the edge number at which they must appear.
    int          init_cnt [2];
    int          edge_n   [2] = '{0, 0};
    logic [31:0] mem_m    [2][64];
    logic        exp_rvalid [2];
    logic [31:0] exp_rdata  [2];
    logic [31:0] exp_q_a[$];
    logic [31:0] exp_q_b[$];
    int          due_q_a[$];
    int          due_q_b[$];

    function automatic int size_of(input int inst);
        return (inst == 0) ? 48 : 64;
    endfunction

    function automatic int lat_of(input int inst);
        return (inst == 0) ? 3 : 1;
    endfunction

    function automatic int rdw_of(input int inst);
        return (inst == 0) ? 1 : 0;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int l = 0; l < 4; l++) begin
            if (we[l]) r[l*8 +: 8] = wd[l*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic exp_ready(input int inst);
        return !reset && (init_cnt[inst] >= size_of(inst));
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset(input int inst);
        init_cnt[inst]   = 0;
        exp_rvalid[inst] = 1'b0;
        exp_rdata[inst]  = 32'h0;
        if (inst == 0) begin
            exp_q_a.delete();
            due_q_a.delete();
        end else begin
            exp_q_b.delete();
            due_q_b.delete();
        end
    endtask

    task automatic model_edge(input int inst);
        int          sz;
        int          due;
        logic [31:0] d;
        sz = size_of(inst);
        edge_n[inst]++;
        exp_rvalid[inst] = 1'b0;
        if (init_cnt[inst] < sz) begin
            init_cnt[inst]++;
            if (init_cnt[inst] == sz) begin
                for (int a = 0; a < 64; a++) mem_m[inst][a] = 32'h0;
            end
        end else begin
            if (read) begin
                d = 32'h0;
                if (int'(raddr) < sz) begin
                    d = mem_m[inst][raddr];
                    if (rdw_of(inst) == 1 && write && waddr == raddr) d = merge(d, wdata, wren);
                end
                due = edge_n[inst] + lat_of(inst) - 1;
                if (inst == 0) begin
                    exp_q_a.push_back(d);
                    due_q_a.push_back(due);
                end else begin
                    exp_q_b.push_back(d);
                    due_q_b.push_back(due);
                end
            end
            if (write && int'(waddr) < sz) begin
                mem_m[inst][waddr] = merge(mem_m[inst][waddr], wdata, wren);
            end
        end
        if (inst == 0) begin
            if (due_q_a.size() > 0 && due_q_a[0] == edge_n[0]) begin
                exp_rdata[0]  = exp_q_a.pop_front();
                due           = due_q_a.pop_front();
                exp_rvalid[0] = 1'b1;
            end
        end else begin
            if (due_q_b.size() > 0 && due_q_b[0] == edge_n[1]) begin
                exp_rdata[1]  = exp_q_b.pop_front();
                due           = due_q_b.pop_front();
                exp_rvalid[1] = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("ready_a",  32'(ready_a),  32'(exp_ready(0)));
        check_eq("rvalid_a", 32'(rvalid_a), 32'(exp_rvalid[0]));
        check_eq("rdata_a",  rdata_a,       exp_rdata[0]);
        check_eq("ready_b",  32'(ready_b),  32'(exp_ready(1)));
        check_eq("rvalid_b", 32'(rvalid_b), 32'(exp_rvalid[1]));
        check_eq("rdata_b",  rdata_b,       exp_rdata[1]);
    endtask

    // One clock: check what the last edge produced, then drive the next edge's inputs.
    task automatic cycle(input logic rst_i, input logic rd_i, input logic [5:0] ra,
                         input logic wr_i, input logic [3:0] we, input logic [5:0] wa,
                         input logic [31:0] wd);
        @(negedge clk);
        check_outputs();
        reset = rst_i;
        read  = rd_i;
        raddr = ra;
        write = wr_i;
        wren  = we;
        waddr = wa;
        wdata = wd;
        if (rst_i) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_edge(0);
            model_edge(1);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 6'd0, 1'b0, 4'h0, 6'd0, 32'h0);
    endtask

    task automatic rand_cycle(input logic narrow);
        logic [5:0] ra;
        logic [5:0] wa;
        ra = narrow ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
        wa = narrow ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
        cycle(1'b0, 1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), wa, $urandom);
    endtask

    task automatic read_all();
        for (int a = 0; a < 64; a++) cycle(1'b0, 1'b1, 6'(a), 1'b0, 4'h0, 6'd0, 32'h0);
        idle(4);
    endtask

    initial begin
        reset = 1'b1;
        read  = 1'b0;
        raddr = '0;
        write = 1'b0;
        wren  = '0;
        waddr = '0;
        wdata = '0;
        for (int a = 0; a < 64; a++) begin
            mem_m[0][a] = 32'h0;
            mem_m[1][a] = 32'h0;
        end
        model_reset(0);
        model_reset(1);

        repeat (3) cycle(1'b1, 1'b0, 6'd0, 1'b0, 4'h0, 6'd0, 32'h0);

        // INIT window with traffic that must be ignored
        for (int i = 0; i < 70; i++) rand_cycle(1'b0);
        read_all();

        // lane-masked writes
        cycle(1'b0, 1'b0, 6'd0, 1'b1, 4'hF, 6'd5, 32'hAABBCCDD);
        cycle(1'b0, 1'b0, 6'd0, 1'b1, 4'h5, 6'd5, 32'h11223344);
        cycle(1'b0, 1'b1, 6'd5, 1'b0, 4'h0, 6'd0, 32'h0);
        idle(4);

        // back-to-back reads through the pipeline, then hold
        for (int a = 1; a <= 3; a++) cycle(1'b0, 1'b0, 6'd0, 1'b1, 4'hF, 6'(a), 32'(a));
        for (int a = 1; a <= 3; a++) cycle(1'b0, 1'b1, 6'(a), 1'b0, 4'h0, 6'd0, 32'h0);
        idle(6);

        // same-edge read/write, then write-then-read
        cycle(1'b0, 1'b1, 6'd7, 1'b1, 4'h3, 6'd7, 32'hFFFFFFFF);
        cycle(1'b0, 1'b1, 6'd7, 1'b0, 4'h0, 6'd0, 32'h0);
        cycle(1'b0, 1'b0, 6'd0, 1'b1, 4'hF, 6'd9, 32'h0BADF00D);
        cycle(1'b0, 1'b1, 6'd9, 1'b0, 4'h0, 6'd0, 32'h0);
        idle(4);

        // address beyond SIZE on the 48-word instance
        cycle(1'b0, 1'b0, 6'd0, 1'b1, 4'hF, 6'd50, 32'h5);
        cycle(1'b0, 1'b1, 6'd50, 1'b0, 4'h0, 6'd0, 32'h0);
        idle(4);
        read_all();

        for (int i = 0; i < 300; i++) rand_cycle(1'b1);
        for (int i = 0; i < 200; i++) rand_cycle(1'b0);

        // reset with reads in flight, then reset again partway through INIT
        cycle(1'b0, 1'b1, 6'd1, 1'b0, 4'h0, 6'd0, 32'h0);
        cycle(1'b0, 1'b1, 6'd2, 1'b0, 4'h0, 6'd0, 32'h0);
        cycle(1'b1, 1'b0, 6'd0, 1'b0, 4'h0, 6'd0, 32'h0);
        cycle(1'b1, 1'b0, 6'd0, 1'b0, 4'h0, 6'd0, 32'h0);
        for (int i = 0; i < 20; i++) rand_cycle(1'b0);
        cycle(1'b1, 1'b0, 6'd0, 1'b0, 4'h0, 6'd0, 32'h0);
        for (int i = 0; i < 80; i++) rand_cycle(1'b0);
        read_all();

        for (int i = 0; i < 200; i++) rand_cycle(1'b1);
        idle(5);
        @(negedge clk);
        check_outputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
